// File: rtl/rx_src_arbiter_pkg.sv
// Shared definitions for the receive-source arbiter and its round-robin picker.
//   arb_state_e : FSM encoding (IDLE = 0, LOCK = 1)
//   idx_w()     : width of a source index; never less than 1 bit, so a
//                 single-source build still has a usable grant_id port.
package rx_src_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rx_src_arbiter_rr_pick.sv
// Combinational round-robin picker. It searches req upward from last+1 and
// wraps modulo NUM_SRC, so the source granted last has the lowest priority.
//   req  : request vector, one bit per source
//   last : index of the previously served source
//   any  : at least one request is set
//   idx  : index of the winning request (0 when any == 0)
module rr_pick
    import rx_src_arbiter_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // base < NUM_SRC and k <= NUM_SRC, so one subtraction is a full modulo.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return s[IDX_W-1:0];
    endfunction

    // The walk runs from the farthest offset to the nearest one. The last
    // hit overwrites the earlier ones, so the closest requester after last wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (req[wrap_add(last, k)]) begin
                any = 1'b1;
                idx = wrap_add(last, k);
            end
        end
    end

endmodule

// File: rtl/rx_src_arbiter.sv
// Shares one valid/ready receive port between NUM_SRC senders. Arbitration is
// round-robin. A winner stays locked for up to MAX_BURST beats, or until it
// drops valid. The block stores no data: in LOCK, the valid, data and ready
// paths are pure muxes.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | sink idle; pick the next requester after last_grant, one bubble
// LOCK  | grant_id is routed to the sink; count beats until the burst ends
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   src_valid  : per-source valid
//   src_data   : source i is at [i*DATA_W +: DATA_W]
//   src_ready  : per-source ready, at most one bit high
//   snk_valid  : valid to the receiver
//   snk_data   : data to the receiver, 0 outside LOCK
//   snk_ready  : ready from the receiver
//   grant_id   : currently locked source (holds its value through IDLE)
//   busy       : high in LOCK
module rx_src_arbiter
    import rx_src_arbiter_pkg::*;
#(
    parameter  int NUM_SRC   = 4,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BURST = 8,
    localparam int IDX_W     = idx_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      snk_valid,
    output logic [DATA_W-1:0]         snk_data,
    input  logic                      snk_ready,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    arb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  grant_nxt;
    logic [IDX_W-1:0]  last_grant, last_nxt;
    logic [7:0]        beat_cnt, beat_nxt;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              hs;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req  (src_valid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == IDX_W'(i)) begin
                sel_valid = src_valid[i];
                sel_data  = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        beat_nxt  = beat_cnt;
        snk_valid = 1'b0;
        snk_data  = '0;
        src_ready = '0;
        busy      = 1'b0;
        hs        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_idx;
                    beat_nxt  = '0;
                    state_nxt = ST_LOCK;
                end
            end
            ST_LOCK: begin
                busy                = 1'b1;
                snk_valid           = sel_valid;
                snk_data            = sel_data;
                src_ready[grant_id] = snk_ready;
                hs                  = sel_valid & snk_ready;
                if (hs && beat_cnt != 8'hFF) beat_nxt = beat_cnt + 8'd1;
                // When valid is low, no beat can be pending, so releasing the
                // grant here cannot drop data.
                if ((hs && beat_cnt == LAST_BEAT) || !sel_valid) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = grant_id;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
